led_step_ticker: RTL and testbench
==================================

// Module: led_step_ticker
// PURPOSE
//  Upstream step generator for the LED pattern sequencer: emits a one-cycle step pulse (en_out)
//  at a selectable rate; the sequencer advances one pattern step per pulse.
//  Debounces two raw push-buttons: RUN toggles free-running stepping, STEP issues one manual step while paused.
//  Replaces tying the sequencer's en high, which advances the pattern every clk and is invisible on LEDs.
// PARAMETERS
//  CNT_W      26          width of rate prescaler counter
//  PERIOD0    50_000_000  clk cycles between steps, speed_sel=0 (slowest)
//  PERIOD1    25_000_000  clk cycles between steps, speed_sel=1
//  PERIOD2    12_500_000  clk cycles between steps, speed_sel=2
//  PERIOD3    6_250_000   clk cycles between steps, speed_sel=3 (fastest); all PERIODn >= 2, < 2**CNT_W
//  DB_W       20          width of debounce counters
//  DB_CYCLES  1_000_000   cycles a raw button level must hold before accepted; >= 2, < 2**DB_W
// PORTS
//  clk        in   1  single system clock; all logic on posedge clk
//  rst        in   1  synchronous reset, active-high
//  btn_run    in   1  raw asynchronous RUN button, 1 = pressed
//  btn_step   in   1  raw asynchronous STEP button, 1 = pressed
//  speed_sel  in   2  rate select, may change any cycle
//  en_out     out  1  registered one-cycle step pulse to the LED sequencer's en input
//  running    out  1  registered, 1 = free-running stepping active
// BEHAVIOUR
//  Reset (rst=1 at posedge): en_out=0, running=0, prescaler=0, debounce counters=0,
//   debounced levels=0, synchronisers=0, registered speed_sel=0. Reset mid-operation aborts any pending step.
//  Sync: each button passes a 2-flop synchroniser; raw-to-sync latency 2 cycles.
//  Debounce (per button): sync==stable -> counter=0; else counter+1; when counter==DB_CYCLES-1 and
//   sync!=stable: stable<=sync, counter<=0. Glitch shorter than DB_CYCLES cycles never changes stable.
//  Press event: one-cycle internal pulse on stable 0->1. Releases generate no event.
//  RUN press: running toggles on the next posedge.
//  STOPPED -> RUNNING: prescaler starts from 0; first en_out exactly PERIODn cycles after running rises.
//  RUNNING: prescaler increments each cycle; at prescaler==PERIODn-1: prescaler<=0, en_out<=1 next cycle.
//   en_out high exactly 1 cycle per PERIODn cycles; never high 2 consecutive cycles for PERIODn>=2.
//  RUNNING -> STOPPED: prescaler cleared to 0; en_out forced 0 from the cycle running falls.
//  STEP press while stopped: en_out=1 for exactly one cycle, the cycle after the press event.
//  STEP press while running: ignored. RUN and STEP press same cycle: RUN toggle wins, STEP dropped.
//  speed_sel is registered; when new value != registered value: prescaler<=0, no en_out generated
//   that cycle; next en_out PERIOD(new) cycles later. Same value re-applied: no effect.
//  Prescaler compare uses registered speed_sel; prescaler never exceeds PERIODn-1 (no wrap via overflow).
// CONFIGURATION
//  LED_TICK_AUTORUN_EN defined: reset value of running is 1; prescaler begins counting in the first
//   cycle after rst deasserts; first en_out PERIOD0 cycles after rst falls. RUN still toggles.
//  Not defined: running resets to 0; no en_out until RUN or STEP pressed.
// TESTING (bench overrides PERIOD0..3=10,5,3,2, DB_CYCLES=4, CNT_W=8, DB_W=4; macro undefined unless stated)
//  Reset then idle 50 cycles, buttons low -> en_out=0, running=0 throughout.
//  btn_run high 10 cycles -> running rises 2+4+1 cycles after press edge; en_out pulses every 10 cycles,
//   first pulse 10 cycles after running rises.
//  btn_run 3-cycle glitch (shorter than DB_CYCLES) -> running unchanged, no en_out.
//  Running, speed_sel 0->3 mid-count -> prescaler restarts; next pulse 2 cycles later, then every 2.
//  Stopped, btn_step pressed 3 separate times -> exactly 3 one-cycle en_out pulses; running press +
//   step press same cycle -> running=1, no extra pulse.
//  rst asserted mid-count while running -> en_out=0, running=0 next cycle; with LED_TICK_AUTORUN_EN,
//   running=1 after reset and first en_out 10 cycles after rst falls.

Source files
------------

// File: rtl/led_step_ticker.sv
// Step-pulse generator for the LED pattern sequencer: debounced RUN/STEP buttons and a rate prescaler.
// Optional build macro LED_TICK_AUTORUN_EN makes stepping free-run straight out of reset.
module led_step_ticker #(
   parameter int CNT_W     = 26,
   parameter int PERIOD0   = 50_000_000,
   parameter int PERIOD1   = 25_000_000,
   parameter int PERIOD2   = 12_500_000,
   parameter int PERIOD3   = 6_250_000,
   parameter int DB_W      = 20,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic [1:0] speed_sel,
   output logic       en_out,
   output logic       running
);

   localparam logic [CNT_W-1:0] P0_LAST = CNT_W'(PERIOD0 - 1);
   localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(PERIOD1 - 1);
   localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(PERIOD2 - 1);
   localparam logic [CNT_W-1:0] P3_LAST = CNT_W'(PERIOD3 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);

`ifdef LED_TICK_AUTORUN_EN
   localparam logic RUN_RST = 1'b1;
`else
   localparam logic RUN_RST = 1'b0;
`endif

   // Button bit 0 is RUN, bit 1 is STEP.
   logic [1:0]      sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   logic [CNT_W-1:0] presc_q, presc_d, period_last_s;
   logic [1:0]       spd_q;
   logic             spd_chg_s;
   logic             running_q, running_d, en_q, en_d;

   function automatic logic [CNT_W-1:0] period_last(input logic [1:0] sel);
      case (sel)
         2'd0:    return P0_LAST;
         2'd1:    return P1_LAST;
         2'd2:    return P2_LAST;
         2'd3:    return P3_LAST;
         default: return P0_LAST;
      endcase
   endfunction

   // A level is accepted only after it has differed from the stable value for DB_CYCLES cycles.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         stable_d[i] = stable_q[i];
         press_d[i]  = 1'b0;
         if (sync2_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            stable_d[i] = sync2_q[i];
            press_d[i]  = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
         end
      end
   end

   assign period_last_s = period_last(spd_q);
   assign spd_chg_s     = (speed_sel != spd_q);

   // RUN press has priority over everything; a stopped ticker only emits manual steps.
   always_comb begin
      running_d = running_q;
      presc_d   = presc_q;
      en_d      = 1'b0;
      if (press_q[0]) begin
         running_d = ~running_q;
         presc_d   = '0;
      end else if (running_q) begin
         if (spd_chg_s) begin
            presc_d = '0;
         end else if (presc_q == period_last_s) begin
            presc_d = '0;
            en_d    = 1'b1;
         end else begin
            presc_d = presc_q + CNT_ONE;
         end
      end else begin
         presc_d = '0;
         en_d    = press_q[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 2'b00;
         sync2_q   <= 2'b00;
         stable_q  <= 2'b00;
         press_q   <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
         presc_q   <= '0;
         spd_q     <= 2'd0;
         running_q <= RUN_RST;
         en_q      <= 1'b0;
      end else begin
         sync1_q   <= {btn_step, btn_run};
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         press_q   <= press_d;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
         presc_q   <= presc_d;
         spd_q     <= speed_sel;
         running_q <= running_d;
         en_q      <= en_d;
      end
   end

   assign en_out  = en_q;
   assign running = running_q;

endmodule

// File: tb/tb_led_step_ticker.sv
// Scoreboard bench for led_step_ticker: stimulus queues expected pulse/transition cycles, a monitor checks them.
module tb_led_step_ticker;

   logic       clk = 1'b0;
   logic       rst, btn_run, btn_step;
   logic [1:0] speed_sel;
   logic       en_out, running;

   int  cyc = 0;
   int  total = 0;
   int  passed = 0;
   int  en_q[$];
   int  run_q[$];
   bit  mon_en = 1'b0;
   logic run_prev;

   led_step_ticker #(
      .CNT_W(8), .PERIOD0(10), .PERIOD1(5), .PERIOD2(3), .PERIOD3(2),
      .DB_W(4), .DB_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
      .speed_sel(speed_sel), .en_out(en_out), .running(running)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_en(input int first, input int last, input int step);
      for (int t = first; t <= last; t += step) en_q.push_back(t);
   endtask

   // Monitor: every en_out pulse and running transition must match the head of its queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (en_out) begin
            if (en_q.size() == 0) check("en_out unexpected pulse", cyc, -1);
            else check("en_out pulse cycle", cyc, en_q.pop_front());
         end
         if (running !== run_prev) begin
            if (run_q.size() == 0) check("running unexpected change", cyc, -1);
            else begin
               int e;
               e = run_q.pop_front();
               check("running change cycle", cyc, e / 2);
               check("running value", int'(running), e % 2);
            end
         end
      end
      run_prev <= running;
   end

   initial begin
      int n, m, p, s, t, q;
      rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; speed_sel = 2'd0;
      tick(3);
      check("reset en_out", int'(en_out), 0);
`ifdef LED_TICK_AUTORUN_EN
      check("reset running autorun", int'(running), 1);
      n = cyc;
      rst = 1'b0;
      mon_en = 1'b1;
      push_en(n + 10, n + 30, 10);
      tick(35);
      q = cyc;
      rst = 1'b1;
      tick(1);
      check("mid reset en_out", int'(en_out), 0);
      check("mid reset running autorun", int'(running), 1);
      rst = 1'b0;
      push_en(q + 11, q + 21, 10);
      tick(25);
`else
      check("reset running", int'(running), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(10);
         check("idle en_out", int'(en_out), 0);
         check("idle running", int'(running), 0);
      end

      btn_run = 1'b1; tick(3); btn_run = 1'b0;
      tick(20);
      check("glitch running", int'(running), 0);

      n = cyc;
      btn_run = 1'b1;
      run_q.push_back((n + 7) * 2 + 1);
      push_en(n + 17, n + 37, 10);
      tick(10); btn_run = 1'b0; tick(30);

      m = cyc;
      speed_sel = 2'd3;
      push_en(m + 3, m + 15, 2);
      tick(10);

      p = cyc;
      btn_run = 1'b1;
      run_q.push_back((p + 7) * 2 + 0);
      tick(10); btn_run = 1'b0; tick(5);
      speed_sel = 2'd0;
      tick(15);
      check("stopped running", int'(running), 0);

      for (int k = 0; k < 3; k++) begin
         s = cyc;
         btn_step = 1'b1;
         en_q.push_back(s + 7);
         tick(6); btn_step = 1'b0; tick(14);
      end
      check("after steps running", int'(running), 0);

      t = cyc;
      btn_run = 1'b1; btn_step = 1'b1;
      run_q.push_back((t + 7) * 2 + 1);
      en_q.push_back(t + 17);
      tick(10); btn_run = 1'b0; btn_step = 1'b0;
      tick(12);

      rst = 1'b1;
      run_q.push_back((t + 23) * 2 + 0);
      tick(1);
      check("mid reset en_out", int'(en_out), 0);
      check("mid reset running", int'(running), 0);
      rst = 1'b0;
      tick(20);
      check("post reset running", int'(running), 0);
`endif
      tick(5);
      check("en queue drained", en_q.size(), 0);
      check("running queue drained", run_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
